// File: rtl/bird_hit_scanner_if.sv
// bird_hit_scanner_if
// Groups the plot bus snooped from the draw sequencers, the shoot request
// and the scan result into one bundle.
//   master : game/draw side. Drives plot_* and shoot/aim_*, and receives the results.
//   slave  : bird_hit_scanner. Receives plot_* and shoot/aim_*, and drives busy/hit_*.
//   plot_en/plot_x/plot_y/plot_colour : pixel write toward the VGA adapter
//   shoot/aim_x/aim_y                 : single-cycle scan request and window centre
//   busy, hit_valid, hit, hit_x, hit_y, hit_count : scanner status and result
interface bird_hit_scanner_if;
    logic       plot_en;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       shoot;
    logic [7:0] aim_x;
    logic [6:0] aim_y;
    logic       busy;
    logic       hit_valid;
    logic       hit;
    logic [7:0] hit_x;
    logic [6:0] hit_y;
    logic [7:0] hit_count;

    modport master (
        output plot_en, plot_x, plot_y, plot_colour, shoot, aim_x, aim_y,
        input  busy, hit_valid, hit, hit_x, hit_y, hit_count
    );

    modport slave (
        input  plot_en, plot_x, plot_y, plot_colour, shoot, aim_x, aim_y,
        output busy, hit_valid, hit, hit_x, hit_y, hit_count
    );
endinterface

// File: rtl/bird_hit_scanner.sv
// bird_hit_scanner
// Keeps a 1-bit shadow occupancy bitmap of the 160x120 screen by snooping the
// plot bus. On shoot it scans a (2*RADIUS+1)^2 window around the aim point in
// row-major order, and it reports whether any pixel in that window is lit, plus the
// coordinates of the first lit pixel it finds.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high. Starts the bitmap clear sweep.
//   bus   : bird_hit_scanner_if.slave (plot bus, shoot request, results)
// Parameter: RADIUS (0..3), the half-width of the window.
// Optional feature: define HIT_SCANNER_SCORE_EN to enable the saturating
// hit_count counter. When it is not defined, hit_count is tied to 0.
module bird_hit_scanner #(
    parameter int RADIUS = 1
) (
    input  logic              clock,
    input  logic              reset,
    bird_hit_scanner_if.slave bus
);
    localparam int PIXELS = 19200;
    localparam logic signed [8:0] R_POS = 9'(RADIUS);
    localparam logic signed [8:0] R_NEG = -R_POS;

    typedef enum logic [2:0] {CLEAR, IDLE, SCAN, DRAIN, REPORT} state_t;

    state_t             state_reg;
    logic [14:0]        clr_addr_reg;
    logic [7:0]         aim_x_reg;
    logic [6:0]         aim_y_reg;
    logic signed [8:0]  dx_reg;
    logic signed [8:0]  dy_reg;
    logic               rd_valid_reg;
    logic [7:0]         rd_x_reg;
    logic [6:0]         rd_y_reg;
    logic               lit_reg;
    logic [7:0]         rec_x_reg;
    logic [6:0]         rec_y_reg;
    logic               busy_reg;
    logic               hit_valid_reg;
    logic               hit_reg;
    logic [7:0]         hit_x_reg;
    logic [6:0]         hit_y_reg;

    // The row address is y*160 + x, computed as (y<<7) + (y<<5) + x.
    function automatic logic [14:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    endfunction

    // Current window position. It is signed so that positions left of or above
    // the screen fall out as negative values.
    logic signed [8:0] win_x;
    logic signed [8:0] win_y;
    logic              win_in;
    logic [14:0]       rd_addr;

    assign win_x   = $signed({1'b0, aim_x_reg}) + dx_reg;
    assign win_y   = $signed({2'b0, aim_y_reg}) + dy_reg;
    assign win_in  = !win_x[8] && (win_x < 9'sd160) && !win_y[8] && (win_y < 9'sd120);
    assign rd_addr = win_in ? pixel_addr(win_x[7:0], win_y[6:0]) : 15'd0;

    // The write port is owned by the clear sweep while in CLEAR. Otherwise it
    // follows the plot bus. Off-screen parking writes are dropped.
    logic        plot_ok;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic        wr_data;

    assign plot_ok = bus.plot_en && (bus.plot_x < 8'd160) && (bus.plot_y < 7'd120);
    assign wr_en   = (state_reg == CLEAR) || plot_ok;
    assign wr_addr = (state_reg == CLEAR) ? clr_addr_reg : pixel_addr(bus.plot_x, bus.plot_y);
    assign wr_data = (state_reg == CLEAR) ? 1'b0 : (bus.plot_colour != 3'd0);

    // Simple dual-port bitmap. The read is registered, and a read at the same
    // address as a write in the same cycle returns the old data.
    logic bitmap [0:PIXELS-1];
    logic rd_data_reg;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            bitmap[wr_addr] <= wr_data;
        end
        rd_data_reg <= bitmap[rd_addr];
    end

    // Only the first lit pixel in scan order is recorded.
    logic hit_take;
    assign hit_take = rd_valid_reg && rd_data_reg && !lit_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= CLEAR;
            clr_addr_reg  <= 15'd0;
            aim_x_reg     <= 8'd0;
            aim_y_reg     <= 7'd0;
            dx_reg        <= 9'sd0;
            dy_reg        <= 9'sd0;
            rd_valid_reg  <= 1'b0;
            rd_x_reg      <= 8'd0;
            rd_y_reg      <= 7'd0;
            lit_reg       <= 1'b0;
            rec_x_reg     <= 8'd0;
            rec_y_reg     <= 7'd0;
            busy_reg      <= 1'b1;
            hit_valid_reg <= 1'b0;
            hit_reg       <= 1'b0;
            hit_x_reg     <= 8'd0;
            hit_y_reg     <= 7'd0;
        end else begin
            hit_valid_reg <= 1'b0;
            // This tags the read issued this cycle so that its data can be
            // judged one cycle later.
            rd_valid_reg  <= (state_reg == SCAN) && win_in;
            rd_x_reg      <= win_x[7:0];
            rd_y_reg      <= win_y[6:0];
            if (hit_take) begin
                lit_reg   <= 1'b1;
                rec_x_reg <= rd_x_reg;
                rec_y_reg <= rd_y_reg;
            end
            case (state_reg)
                CLEAR: begin
                    if (clr_addr_reg == 15'(PIXELS - 1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        clr_addr_reg <= clr_addr_reg + 15'd1;
                    end
                end
                IDLE: begin
                    if (bus.shoot) begin
                        aim_x_reg <= bus.aim_x;
                        aim_y_reg <= bus.aim_y;
                        dx_reg    <= R_NEG;
                        dy_reg    <= R_NEG;
                        lit_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (dx_reg == R_POS) begin
                        dx_reg <= R_NEG;
                        if (dy_reg == R_POS) begin
                            state_reg <= DRAIN;
                        end else begin
                            dy_reg <= dy_reg + 9'sd1;
                        end
                    end else begin
                        dx_reg <= dx_reg + 9'sd1;
                    end
                end
                DRAIN: begin
                    // The last read's data is consumed by hit_take this cycle.
                    state_reg <= REPORT;
                end
                REPORT: begin
                    hit_valid_reg <= 1'b1;
                    hit_reg       <= lit_reg;
                    if (lit_reg) begin
                        hit_x_reg <= rec_x_reg;
                        hit_y_reg <= rec_y_reg;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.hit_valid = hit_valid_reg;
    assign bus.hit       = hit_reg;
    assign bus.hit_x     = hit_x_reg;
    assign bus.hit_y     = hit_y_reg;

`ifdef HIT_SCANNER_SCORE_EN
    logic [7:0] hit_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_reg <= 8'd0;
        end else if ((state_reg == REPORT) && lit_reg && (hit_count_reg != 8'hFF)) begin
            hit_count_reg <= hit_count_reg + 8'd1;
        end
    end

    assign bus.hit_count = hit_count_reg;
`else
    assign bus.hit_count = 8'd0;
`endif
endmodule

// File: tb/tb_bird_hit_scanner.sv
module tb_bird_hit_scanner;
    localparam int R   = 1;
    localparam int N   = (2 * R + 1) * (2 * R + 1);
    localparam int LAT = N + 2;
`ifdef HIT_SCANNER_SCORE_EN
    localparam bit SCORE = 1'b1;
`else
    localparam bit SCORE = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bird_hit_scanner_if bus();

    bird_hit_scanner #(.RADIUS(R)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       hit;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    bit   model [0:19199];
    int   last_x;
    int   last_y;
    int   exp_count;
    int   checks = 0;
    int   errors = 0;
    int   hv_count = 0;

    always @(negedge clock) begin
        if (bus.hit_valid === 1'b1) hv_count++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic plot(input int x, input int y, input int c);
        @(negedge clock);
        bus.plot_en     = 1'b1;
        bus.plot_x      = x[7:0];
        bus.plot_y      = y[6:0];
        bus.plot_colour = c[2:0];
        @(negedge clock);
        bus.plot_en     = 1'b0;
        if (x < 160 && y < 120) model[y * 160 + x] = (c != 0);
        $display("plot (%0d,%0d) colour %0d", x, y, c);
    endtask

    task automatic wait_clear();
        int cnt;
        cnt = 0;
        while (cnt < 20000) begin
            @(negedge clock);
            cnt++;
            if (bus.busy === 1'b0) break;
        end
        chk("clear_len", cnt, 19200);
        $display("clear sweep done after %0d cycles", cnt);
    endtask

    task automatic shot(input int ax, input int ay, input bit retrig);
        exp_t e;
        exp_t got;
        int   cyc;
        int   hv0;
        int   px;
        int   py;
        e.hit = 1'b0;
        e.x   = 8'(last_x);
        e.y   = 7'(last_y);
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                px = ax + dx;
                py = ay + dy;
                if (px >= 0 && px < 160 && py >= 0 && py < 120 && !e.hit) begin
                    if (model[py * 160 + px]) begin
                        e.hit = 1'b1;
                        e.x   = 8'(px);
                        e.y   = 7'(py);
                    end
                end
            end
        end
        if (e.hit) begin
            last_x = px;
            last_x = int'(e.x);
            last_y = int'(e.y);
            if (SCORE && exp_count < 255) exp_count++;
        end
        e.cnt = 8'(exp_count);
        sb.push_back(e);
        hv0 = hv_count;

        @(negedge clock);
        bus.shoot = 1'b1;
        bus.aim_x = ax[7:0];
        bus.aim_y = ay[6:0];
        @(negedge clock);
        bus.shoot = 1'b0;
        chk("busy_start", int'(bus.busy), 1);
        cyc = 0;
        while (cyc < LAT + 10) begin
            @(negedge clock);
            cyc++;
            if (bus.hit_valid === 1'b1) break;
            if (retrig) bus.shoot = (cyc == 3);
        end
        bus.shoot = 1'b0;
        chk("latency", cyc, LAT);
        got = sb.pop_front();
        chk("hit", int'(bus.hit), int'(got.hit));
        chk("hit_x", int'(bus.hit_x), int'(got.x));
        chk("hit_y", int'(bus.hit_y), int'(got.y));
        chk("hit_count", int'(bus.hit_count), int'(got.cnt));
        chk("busy_end", int'(bus.busy), 0);
        $display("shoot (%0d,%0d): hit=%0d x=%0d y=%0d count=%0d latency=%0d",
                 ax, ay, bus.hit, bus.hit_x, bus.hit_y, bus.hit_count, cyc);
        repeat (3) @(negedge clock);
        chk("single_strobe", hv_count - hv0, 1);
    endtask

    initial begin
        int hv_before;
        bus.plot_en     = 1'b0;
        bus.plot_x      = 8'd0;
        bus.plot_y      = 7'd0;
        bus.plot_colour = 3'd0;
        bus.shoot       = 1'b0;
        bus.aim_x       = 8'd0;
        bus.aim_y       = 7'd0;
        last_x    = 0;
        last_y    = 0;
        exp_count = 0;
        for (int i = 0; i < 19200; i++) model[i] = 1'b0;

        // Reset state and clear sweep length
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(bus.busy), 1);
        chk("rst_hit_valid", int'(bus.hit_valid), 0);
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_hit_x", int'(bus.hit_x), 0);
        chk("rst_hit_y", int'(bus.hit_y), 0);
        chk("rst_hit_count", int'(bus.hit_count), 0);
        reset = 1'b0;
        wait_clear();

        // Empty screen
        shot(80, 60, 1'b0);

        // A single lit pixel, and then the same pixel erased
        plot(81, 61, 7);
        shot(80, 60, 1'b0);
        plot(81, 61, 0);
        shot(80, 60, 1'b0);

        // Screen corners, which have window positions off screen
        plot(0, 0, 5);
        plot(159, 119, 1);
        shot(0, 0, 1'b0);
        shot(159, 119, 1'b0);

        // Off-screen writes must be dropped without aliasing
        plot(255, 127, 7);
        plot(160, 5, 7);
        shot(1, 6, 1'b0);
        shot(80, 60, 1'b0);

        // First hit in row-major order, and a retrigger while busy is ignored
        plot(79, 59, 2);
        plot(81, 61, 3);
        shot(80, 60, 1'b1);

        if (SCORE) begin
            for (int i = 0; i < 300; i++) shot(80, 60, 1'b0);
        end

        // Reset four cycles into a scan
        hv_before = hv_count;
        @(negedge clock);
        bus.shoot = 1'b1;
        bus.aim_x = 8'd80;
        bus.aim_y = 7'd60;
        @(negedge clock);
        bus.shoot = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset_busy", int'(bus.busy), 1);
        chk("midreset_hit_valid", int'(bus.hit_valid), 0);
        chk("midreset_hit_x", int'(bus.hit_x), 0);
        $display("reset asserted mid-scan");
        for (int i = 0; i < 19200; i++) model[i] = 1'b0;
        last_x    = 0;
        last_y    = 0;
        exp_count = 0;
        wait_clear();
        chk("midreset_no_strobe", hv_count - hv_before, 0);
        shot(80, 60, 1'b0);
        shot(0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
